fp_adder_pipe: RTL

- Parametrised, 3-stage pipelined successor to the team's combinational small-float adder.
- Format is sign-magnitude: unsigned EXP_W exponent, FRAC_W fraction with explicit leading 1 (no hidden bit, no bias, no inf/NaN).
- Adds an add/subtract op, a valid/ready stream handshake, selectable rounding, and overflow/underflow/zero flags.
- Sits between operand-stream producers and the result consumer in the datapath.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_adder_pipe_if.sv | 40 ++++
 rtl/fp_lzc.sv | 20 ++
 rtl/fp_adder_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and types for the pipelined small-float adder.
package fp_pkg;

    localparam int unsigned EXP_W_DEF  = 4;
    localparam int unsigned FRAC_W_DEF = 8;

    localparam int unsigned ROUND_TRUNC = 0;
    localparam int unsigned ROUND_RNE   = 1;

    // Guard, round and sticky bits carried below the fraction LSB.
    localparam int unsigned GRS_W = 3;

    typedef struct packed {
        logic                  sign;
        logic [EXP_W_DEF-1:0]  exp;
        logic [FRAC_W_DEF-1:0] frac;
    } fp_t;

endpackage

// File: rtl/fp_adder_pipe_if.sv
// Operand/result stream bundle for fp_adder_pipe.
interface fp_adder_pipe_if
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic              op_sub;
    logic              sign_a;
    logic              sign_b;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [FRAC_W-1:0] frac_a;
    logic [FRAC_W-1:0] frac_b;

    logic              out_valid;
    logic              out_ready;
    logic              sign_out;
    logic [EXP_W-1:0]  exp_out;
    logic [FRAC_W-1:0] frac_out;
    logic              ovf;
    logic              unf;
    logic              zero;

    // Producer/consumer side: drives operands and accepts results.
    modport master (
        output in_valid, op_sub, sign_a, sign_b, exp_a, exp_b, frac_a, frac_b, out_ready,
        input  in_ready, out_valid, sign_out, exp_out, frac_out, ovf, unf, zero
    );

    // Adder side.
    modport slave (
        input  in_valid, op_sub, sign_a, sign_b, exp_a, exp_b, frac_a, frac_b, out_ready,
        output in_ready, out_valid, sign_out, exp_out, frac_out, ovf, unf, zero
    );

endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        cnt_o = CNT_W'(WIDTH);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (in_i[i]) begin
                cnt_o = CNT_W'(int'(WIDTH) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_adder_pipe.sv
// 3-stage pipelined sign-magnitude float adder/subtractor.
// S1 sorts and aligns, S2 adds/subtracts, S3 normalises, rounds and flags.
module fp_adder_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned ROUND  = ROUND_TRUNC
) (
    input logic            clk,
    input logic            reset,
    fp_adder_pipe_if.slave bus
);

    localparam int unsigned W       = FRAC_W + GRS_W;
    localparam int unsigned CNT_W   = $clog2(W + 1);
    // Wide enough to hold exp+1 and exp-L without wrapping.
    localparam int unsigned EW      = EXP_W + CNT_W + 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    logic en;
    logic out_valid_q;

    // Single global stall: the whole pipe moves only when the output slot frees up.
    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

    // ---------------- S1: sort / align ----------------
    logic              sign_b_eff;
    logic              a_big;
    logic              s1_sign_big_d, s1_sign_small_d;
    logic [EXP_W-1:0]  s1_exp_d, exp_small, shift_d;
    logic [FRAC_W-1:0] s1_frac_d, frac_small;
    logic [W-1:0]      small_ext, small_shr, small_lost, s1_aligned_d;

    logic              s1_valid_q, s1_sign_big_q, s1_sign_small_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [FRAC_W-1:0] s1_frac_q;
    logic [W-1:0]      s1_aligned_q;

    // Pick the larger magnitude (b wins ties) and right-align the smaller one.
    always_comb begin
        sign_b_eff      = bus.sign_b ^ bus.op_sub;
        a_big           = {bus.exp_a, bus.frac_a} > {bus.exp_b, bus.frac_b};
        s1_sign_big_d   = a_big ? bus.sign_a : sign_b_eff;
        s1_sign_small_d = a_big ? sign_b_eff : bus.sign_a;
        s1_exp_d        = a_big ? bus.exp_a  : bus.exp_b;
        exp_small       = a_big ? bus.exp_b  : bus.exp_a;
        s1_frac_d       = a_big ? bus.frac_a : bus.frac_b;
        frac_small      = a_big ? bus.frac_b : bus.frac_a;
        shift_d         = s1_exp_d - exp_small;
        small_ext       = {frac_small, {GRS_W{1'b0}}};
        // Shifts of W or more clear the value and leave every bit in the lost mask.
        small_shr       = small_ext >> shift_d;
        small_lost      = small_ext & ~({W{1'b1}} << shift_d);
        s1_aligned_d    = {small_shr[W-1:1], small_shr[0] | (|small_lost)};
    end

    // S1 pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q      <= 1'b0;
            s1_sign_big_q   <= 1'b0;
            s1_sign_small_q <= 1'b0;
            s1_exp_q        <= '0;
            s1_frac_q       <= '0;
            s1_aligned_q    <= '0;
        end else if (en) begin
            s1_valid_q      <= bus.in_valid;
            s1_sign_big_q   <= s1_sign_big_d;
            s1_sign_small_q <= s1_sign_small_d;
            s1_exp_q        <= s1_exp_d;
            s1_frac_q       <= s1_frac_d;
            s1_aligned_q    <= s1_aligned_d;
        end
    end

    // ---------------- S2: add / subtract ----------------
    logic [W-1:0]     big_ext;
    logic [W:0]       s2_sum_d;

    logic             s2_valid_q, s2_sign_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [W:0]       s2_sum_q;

    // Magnitude add or subtract; the result carries the big operand's sign.
    always_comb begin
        big_ext = {s1_frac_q, {GRS_W{1'b0}}};
        if (s1_sign_big_q == s1_sign_small_q) begin
            s2_sum_d = {1'b0, big_ext} + {1'b0, s1_aligned_q};
        end else begin
            s2_sum_d = {1'b0, big_ext} - {1'b0, s1_aligned_q};
        end
    end

    // S2 pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_sum_q   <= '0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_big_q;
            s2_exp_q   <= s1_exp_q;
            s2_sum_q   <= s2_sum_d;
        end
    end

    // ---------------- S3: normalise / round ----------------
    logic [CNT_W-1:0]  lz_cnt;
    logic [W-1:0]      norm_v;
    logic [EW-1:0]     exp_n;
    logic              round_inc;
    logic [FRAC_W:0]   frac_r;
    logic              res_sign, res_ovf, res_unf, res_zero;
    logic [EXP_W-1:0]  res_exp;
    logic [FRAC_W-1:0] res_frac;

    fp_lzc #(
        .WIDTH (W),
        .CNT_W (CNT_W)
    ) u_lzc (
        .in_i  (s2_sum_q[W-1:0]),
        .cnt_o (lz_cnt)
    );

    // Normalise, round, then apply zero / underflow / overflow handling.
    always_comb begin
        res_sign  = 1'b0;
        res_exp   = '0;
        res_frac  = '0;
        res_ovf   = 1'b0;
        res_unf   = 1'b0;
        res_zero  = 1'b0;
        norm_v    = '0;
        exp_n     = '0;
        round_inc = 1'b0;
        frac_r    = '0;

        if (s2_sum_q == '0) begin
            res_zero = 1'b1;
        end else if (s2_sum_q[W]) begin
            norm_v = {s2_sum_q[W:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n  = EW'(s2_exp_q) + EW'(1);
        end else if (EW'(lz_cnt) > EW'(s2_exp_q)) begin
            res_unf = 1'b1;
        end else begin
            norm_v = s2_sum_q[W-1:0] << lz_cnt;
            exp_n  = EW'(s2_exp_q) - EW'(lz_cnt);
        end

        if (!res_zero && !res_unf) begin
            // G && (R || S || lsb); only active in round-to-nearest-even mode.
            round_inc = (ROUND == ROUND_RNE) && norm_v[GRS_W-1]
                        && (norm_v[GRS_W-2] || norm_v[0] || norm_v[GRS_W]);
            frac_r    = {1'b0, norm_v[W-1:GRS_W]} + (FRAC_W + 1)'(round_inc);
            if (frac_r[FRAC_W]) begin
                frac_r = {2'b01, {(FRAC_W - 1){1'b0}}};
                exp_n  = exp_n + EW'(1);
            end
            res_sign = s2_sign_q;
            if (exp_n > EW'(EXP_MAX)) begin
                res_ovf  = 1'b1;
                res_exp  = '1;
                res_frac = '1;
            end else begin
                res_exp  = exp_n[EXP_W-1:0];
                res_frac = frac_r[FRAC_W-1:0];
            end
        end
    end

    logic              out_sign_q, out_ovf_q, out_unf_q, out_zero_q;
    logic [EXP_W-1:0]  out_exp_q;
    logic [FRAC_W-1:0] out_frac_q;

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_frac_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else if (en) begin
            out_valid_q <= s2_valid_q;
            out_sign_q  <= res_sign;
            out_exp_q   <= res_exp;
            out_frac_q  <= res_frac;
            out_ovf_q   <= res_ovf;
            out_unf_q   <= res_unf;
            out_zero_q  <= res_zero;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sign_out  = out_sign_q;
    assign bus.exp_out   = out_exp_q;
    assign bus.frac_out  = out_frac_q;
    assign bus.ovf       = out_ovf_q;
    assign bus.unf       = out_unf_q;
    assign bus.zero      = out_zero_q;

endmodule
